frame_depth_store: RTL and testbench
====================================

// Module: frame_depth_store
// PURPOSE
//  Synthesizable frame buffer + Z-buffer store behind the rasterizer, generalised in resolution, colour and depth width.
//  Serves rasterizer Z reads (1-cycle latency) and FB/ZB writes, a hardware clear sequencer, and a ready/valid scanout port.
//  Scanout streams row-major pixels, optionally bottom-row-first, to the display or capture path.
// PARAMETERS
//  H_RES        320   pixels per row
//  V_RES        240   rows; N = H_RES*V_RES
//  COLOR_W      12    FB pixel width (4R4G4B at default)
//  Z_W          8     depth width; larger = farther
//  ADDR_W       17    address width; must satisfy 2**ADDR_W >= N
//  CLEAR_COLOR  0     FB fill value on clear
//  CLEAR_Z      '1    ZB fill value on clear (far plane)
//  FLIP_Y       1     1: scanout starts at row V_RES-1; 0: starts at row 0
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous active-high reset
//  i_clear_start in   1        pulse: begin clearing both memories
//  o_clear_busy  out  1        clear in progress; upstream stalls writes
//  o_clear_done  out  1        1-cycle pulse after last clear write
//  i_zb_r_addr   in   ADDR_W   Z read address
//  o_zb_r_data   out  Z_W      Z read data, valid 1 cycle after address
//  i_zb_w_we     in   1        Z write enable
//  i_zb_w_addr   in   ADDR_W   Z write address
//  i_zb_w_data   in   Z_W      Z write data
//  i_fb_we       in   1        FB write enable
//  i_fb_addr     in   ADDR_W   FB write address
//  i_fb_pixel    in   COLOR_W  FB write data
//  i_scan_start  in   1        pulse: begin one full-frame scanout
//  o_scan_busy   out  1        scanout in progress
//  o_scan_valid  out  1        scanout beat valid
//  i_scan_ready  in   1        scanout sink ready
//  o_scan_pixel  out  COLOR_W  pixel data
//  o_scan_x      out  ADDR_W   column of beat
//  o_scan_y      out  ADDR_W   buffer row of beat (unflipped index)
//  o_scan_last   out  1        final beat of frame
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE; memory contents NOT reset. Reset mid-clear/scan aborts, no done pulse, no last beat.
//  - FSM: IDLE -> CLEAR on i_clear_start; IDLE -> SCAN on i_scan_start (clear wins if both same cycle); CLEAR/SCAN -> IDLE.
//  - Start pulses arriving outside IDLE are ignored (no queueing).
//  - CLEAR: one address per cycle, 0..N-1, writes CLEAR_COLOR and CLEAR_Z; busy rises cycle after start, N cycles long.
//    o_clear_done pulses the cycle busy falls. External FB/ZB writes during CLEAR are dropped; Z reads return memory contents.
//  - Writes: FB and ZB write ports independent, same cycle allowed; addr >= N ignored. Z read addr >= N returns CLEAR_Z.
//  - Read/write same ZB address same cycle: read returns OLD value (read-first) unless ZB_READ_BYPASS_EN.
//  - SCAN: first valid 2 cycles after start; 1 beat/cycle while ready high. Beat held stable while valid && !ready.
//    Order: x 0..H_RES-1 within row; rows V_RES-1 down to 0 if FLIP_Y else 0 up. o_scan_last on beat (H_RES-1, final row).
//    Busy falls the cycle after last beat accepted. FB writes during SCAN are accepted; pixel returned reflects RAM at read time.
//  - Counters wrap x at H_RES-1 and step y; no address arithmetic beyond N-1 (no multiplier in scan path: address increments/decrements by row).
// CONFIGURATION
//  - ZB_READ_BYPASS_EN defined: when i_zb_w_we && i_zb_w_addr == i_zb_r_addr (in range, not CLEAR), o_zb_r_data next cycle
//    equals i_zb_w_data (write-first forwarding). Undefined: read-first, old value returned. Latency 1 cycle either way.
// TESTING
//  - rst, i_clear_start -> o_clear_busy high 76800 cycles, done pulse once; Z read addr 0 and 76799 -> 8'hFF, scan pixels all 0.
//  - fb_we addr 321 pixel 12'hF0A, then scan (FLIP_Y=1) -> beat with x=1,y=1 carries 12'hF0A, at beat index 238*320+1.
//  - zb write addr 5 data 8'h10 with same-cycle read addr 5 -> next cycle 8'hFF (bypass off) / 8'h10 (ZB_READ_BYPASS_EN).
//  - Scan with i_scan_ready toggling 1/0 every cycle -> 76800 beats, no drop/duplicate, o_scan_last only on x=319,y=0.
//  - fb_we addr 76800 and i_clear_start during SCAN -> both ignored; rst asserted mid-clear at cycle 100 -> outputs 0, no done.

Source files
------------

// File: rtl/frame_depth_store_if.sv
// Scanout stream bundle for frame_depth_store.
// A beat transfers on a clock edge where valid and ready are both high.
interface frame_depth_store_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 17
);
  logic               valid;
  logic               ready;
  logic [COLOR_W-1:0] pixel;
  logic [ADDR_W-1:0]  x;
  logic [ADDR_W-1:0]  y;
  logic               last;

  modport master (
    output valid, pixel, x, y, last,
    input  ready
  );

  modport slave (
    input  valid, pixel, x, y, last,
    output ready
  );
endinterface

// File: rtl/frame_depth_store.sv
// Frame buffer + Z-buffer store: Z reads, FB/ZB writes, clear sequencer, scanout.
// Define ZB_READ_BYPASS_EN for write-first forwarding on same-address Z read/write.
module frame_depth_store #(
  parameter int               H_RES       = 320,
  parameter int               V_RES       = 240,
  parameter int               COLOR_W     = 12,
  parameter int               Z_W         = 8,
  parameter int               ADDR_W      = 17,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter logic [Z_W-1:0]   CLEAR_Z     = '1,
  parameter bit               FLIP_Y      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear_start,
  output logic              o_clear_busy,
  output logic              o_clear_done,
  input  logic [ADDR_W-1:0] i_zb_r_addr,
  output logic [Z_W-1:0]    o_zb_r_data,
  input  logic              i_zb_w_we,
  input  logic [ADDR_W-1:0] i_zb_w_addr,
  input  logic [Z_W-1:0]    i_zb_w_data,
  input  logic              i_fb_we,
  input  logic [ADDR_W-1:0] i_fb_addr,
  input  logic [COLOR_W-1:0] i_fb_pixel,
  input  logic              i_scan_start,
  output logic              o_scan_busy,
  frame_depth_store_if.master scan
);

  localparam int N = H_RES * V_RES;
  localparam logic [ADDR_W:0]   N_A      = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(H_RES - 1);
  localparam logic [ADDR_W-1:0] Y_FIRST  =
    FLIP_Y ? ADDR_W'(V_RES - 1) : '0;
  localparam logic [ADDR_W-1:0] Y_FINAL  =
    FLIP_Y ? '0 : ADDR_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] A_FIRST  =
    FLIP_Y ? ADDR_W'((V_RES - 1) * H_RES) : '0;
  localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * H_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN
  } state_e;

  logic [COLOR_W-1:0] fb_mem [N];
  logic [Z_W-1:0]     zb_mem [N];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic               done_q, done_d;
  logic [Z_W-1:0]     zrd_q, zrd_d;
  logic [ADDR_W-1:0]  sa_q, sa_d;
  logic [ADDR_W-1:0]  sx_q, sx_d;
  logic [ADDR_W-1:0]  sy_q, sy_d;
  logic               pend_q, pend_d;
  logic               valid_q, valid_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0]  ox_q, ox_d;
  logic [ADDR_W-1:0]  oy_q, oy_d;
  logic               last_q, last_d;

  logic               in_clear;
  logic               fb_we, zb_we;
  logic [ADDR_W-1:0]  fb_wa, zb_wa;
  logic [COLOR_W-1:0] fb_wd;
  logic [Z_W-1:0]     zb_wd;
  logic               adv, row_end;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < N_A;
  endfunction

  assign in_clear = (state_q == S_CLEAR);

  // The clear sequencer owns both write ports while it runs
  always_comb begin
    fb_we = in_clear || (i_fb_we && in_range(i_fb_addr));
    fb_wa = in_clear ? clr_q : i_fb_addr;
    fb_wd = in_clear ? CLEAR_COLOR : i_fb_pixel;
    zb_we = in_clear || (i_zb_w_we && in_range(i_zb_w_addr));
    zb_wa = in_clear ? clr_q : i_zb_w_addr;
    zb_wd = in_clear ? CLEAR_Z : i_zb_w_data;
  end

  always_ff @(posedge clk) begin
    if (fb_we) fb_mem[fb_wa] <= fb_wd;
  end

  always_ff @(posedge clk) begin
    if (zb_we) zb_mem[zb_wa] <= zb_wd;
  end

  always_comb begin
    zrd_d = CLEAR_Z;
    if (in_range(i_zb_r_addr)) zrd_d = zb_mem[i_zb_r_addr];
`ifdef ZB_READ_BYPASS_EN
    if (!in_clear && i_zb_w_we &&
        i_zb_w_addr == i_zb_r_addr &&
        in_range(i_zb_r_addr))
      zrd_d = i_zb_w_data;
`else
`endif
  end

  assign adv     = !valid_q || scan.ready;
  assign row_end = (sx_q == X_LAST);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
    sa_d    = sa_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    pix_d   = pix_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_clear_start) begin
          state_d = S_CLEAR;
          clr_d   = '0;
        end else if (i_scan_start) begin
          state_d = S_SCAN;
          sa_d    = A_FIRST;
          sx_d    = '0;
          sy_d    = Y_FIRST;
          pend_d  = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST_A) begin
          state_d = S_IDLE;
          clr_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_SCAN: begin
        if (adv) begin
          valid_d = pend_q;
          if (pend_q) begin
            pix_d  = fb_mem[sa_q];
            ox_d   = sx_q;
            oy_d   = sy_q;
            last_d = row_end && (sy_q == Y_FINAL);
            if (row_end && (sy_q == Y_FINAL)) pend_d = 1'b0;
            // Row step walks the linear address; no multiply needed
            if (row_end) begin
              sx_d = '0;
              if (FLIP_Y) begin
                sy_d = sy_q - 1'b1;
                sa_d = sa_q - ROW_BACK;
              end else begin
                sy_d = sy_q + 1'b1;
                sa_d = sa_q + 1'b1;
              end
            end else begin
              sx_d = sx_q + 1'b1;
              sa_d = sa_q + 1'b1;
            end
          end else begin
            last_d = 1'b0;
            if (valid_q && last_q) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      done_q  <= 1'b0;
      zrd_q   <= '0;
      sa_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      zrd_q   <= zrd_d;
      sa_q    <= sa_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      pix_q   <= pix_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      last_q  <= last_d;
    end
  end

  assign o_clear_busy = in_clear;
  assign o_clear_done = done_q;
  assign o_zb_r_data  = zrd_q;
  assign o_scan_busy  = (state_q == S_SCAN);
  assign scan.valid   = valid_q;
  assign scan.pixel   = pix_q;
  assign scan.x       = ox_q;
  assign scan.y       = oy_q;
  assign scan.last    = last_q;

endmodule

// File: tb/tb_frame_depth_store.sv
// Bench for frame_depth_store at a reduced 8x6 frame.
// Honours ZB_READ_BYPASS_EN when choosing Z read expectations.
module tb_frame_depth_store;
  localparam int H  = 8;
  localparam int V  = 6;
  localparam int N  = H * V;
  localparam int AW = 6;
  localparam int CW = 12;
  localparam int ZW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_clear_start;
  logic          o_clear_busy;
  logic          o_clear_done;
  logic [AW-1:0] i_zb_r_addr;
  logic [ZW-1:0] o_zb_r_data;
  logic          i_zb_w_we;
  logic [AW-1:0] i_zb_w_addr;
  logic [ZW-1:0] i_zb_w_data;
  logic          i_fb_we;
  logic [AW-1:0] i_fb_addr;
  logic [CW-1:0] i_fb_pixel;
  logic          i_scan_start;
  logic          o_scan_busy;

  frame_depth_store_if #(.COLOR_W(CW), .ADDR_W(AW)) sif ();

  frame_depth_store #(
    .H_RES(H), .V_RES(V), .COLOR_W(CW), .Z_W(ZW), .ADDR_W(AW),
    .CLEAR_COLOR(12'h000), .CLEAR_Z(8'hFF), .FLIP_Y(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_clear_start(i_clear_start),
    .o_clear_busy(o_clear_busy),
    .o_clear_done(o_clear_done),
    .i_zb_r_addr(i_zb_r_addr),
    .o_zb_r_data(o_zb_r_data),
    .i_zb_w_we(i_zb_w_we),
    .i_zb_w_addr(i_zb_w_addr),
    .i_zb_w_data(i_zb_w_data),
    .i_fb_we(i_fb_we),
    .i_fb_addr(i_fb_addr),
    .i_fb_pixel(i_fb_pixel),
    .i_scan_start(i_scan_start),
    .o_scan_busy(o_scan_busy),
    .scan(sif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] fbm [N];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [ZW-1:0] wd;
    logic [AW-1:0] ra;
    logic [ZW-1:0] exp_rf;
    logic [ZW-1:0] exp_wf;
  } zv_t;

  zv_t zt [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [CW-1:0] p,
                                     input logic [AW-1:0] x,
                                     input logic [AW-1:0] y,
                                     input logic l, input logic v);
    return {6'b0, p, x, y, l, v};
  endfunction

  function automatic logic [31:0] cur();
    return pk(sif.pixel, sif.x, sif.y, sif.last, sif.valid);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_clear_busy"}, o_clear_busy, 0);
    chk({tag, "_clear_done"}, o_clear_done, 0);
    chk({tag, "_scan_busy"}, o_scan_busy, 0);
    chk({tag, "_zb_r_data"}, o_zb_r_data, 0);
    chk({tag, "_scan_beat"}, cur(), 0);
  endtask

  task automatic run_scan(input bit toggle, input bit inject);
    int beats;
    int lasts;
    bit held_v;
    bit done;
    bit rdy;
    logic [31:0] held;
    int yrow;
    int x;
    beats = 0; lasts = 0; held_v = 0; done = 0; held = '0;
    i_scan_start = 1'b1;
    @(negedge clk);
    i_scan_start = 1'b0;
    chk("scan_busy_rise", o_scan_busy, 1);
    chk("scan_valid_c1", sif.valid, 0);
    @(negedge clk);
    for (int c = 2; c < 1000 && !done; c++) begin
      if (held_v) chk("scan_hold", cur(), held);
      if (c == 2) chk("scan_first_valid", sif.valid, 1);
      if (inject && c == 14) chk("clear_ignored", o_clear_busy, 0);
      rdy = toggle ? (c % 2 == 0) : 1'b1;
      sif.ready = rdy;
      i_fb_we = 1'b0;
      i_clear_start = 1'b0;
      if (inject && c == 12) begin
        i_clear_start = 1'b1;
        i_fb_we = 1'b1; i_fb_addr = 6'd48; i_fb_pixel = 12'hEEE;
      end
      if (inject && c == 13) begin
        i_fb_we = 1'b1; i_fb_addr = 6'd3; i_fb_pixel = 12'h333;
        fbm[3] = 12'h333;
      end
      if (sif.valid && rdy) begin
        x = beats % H;
        yrow = V - 1 - beats / H;
        chk("scan_beat", cur(),
            pk(fbm[yrow*H+x], AW'(x), AW'(yrow), beats == N-1, 1'b1));
        if (beats == 33) chk("scan_f0a_beat", sif.pixel, 12'hF0A);
        if (sif.last) lasts++;
        beats++;
        held_v = 0;
      end else if (sif.valid) begin
        held_v = 1;
        held = cur();
      end else begin
        held_v = 0;
      end
      if (beats == N) done = 1;
      @(negedge clk);
    end
    i_fb_we = 1'b0;
    i_clear_start = 1'b0;
    chk("scan_beats", beats, N);
    chk("scan_lasts", lasts, 1);
    chk("scan_busy_fall", o_scan_busy, 0);
    chk("scan_valid_end", sif.valid, 0);
    sif.ready = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_bad;
    int cnt;
    bit prev_busy;
    logic [ZW-1:0] ze;

    zt[0]  = '{1'b0, 6'd0,  8'h00, 6'd0,  8'hFF, 8'hFF};
    zt[1]  = '{1'b0, 6'd0,  8'h00, 6'd47, 8'hFF, 8'hFF};
    zt[2]  = '{1'b0, 6'd0,  8'h00, 6'd2,  8'hFF, 8'hFF};
    zt[3]  = '{1'b1, 6'd5,  8'h10, 6'd5,  8'hFF, 8'h10};
    zt[4]  = '{1'b0, 6'd0,  8'h00, 6'd5,  8'h10, 8'h10};
    zt[5]  = '{1'b1, 6'd7,  8'h20, 6'd5,  8'h10, 8'h10};
    zt[6]  = '{1'b0, 6'd0,  8'h00, 6'd7,  8'h20, 8'h20};
    zt[7]  = '{1'b1, 6'd48, 8'h55, 6'd48, 8'hFF, 8'hFF};
    zt[8]  = '{1'b0, 6'd0,  8'h00, 6'd48, 8'hFF, 8'hFF};
    zt[9]  = '{1'b1, 6'd9,  8'h44, 6'd9,  8'hFF, 8'h44};
    zt[10] = '{1'b0, 6'd0,  8'h00, 6'd9,  8'h44, 8'h44};
    zt[11] = '{1'b1, 6'd6,  8'h00, 6'd6,  8'hFF, 8'h00};
    zt[12] = '{1'b0, 6'd0,  8'h00, 6'd6,  8'h00, 8'h00};
    zt[13] = '{1'b1, 6'd63, 8'h01, 6'd63, 8'hFF, 8'hFF};

    rst = 1'b1;
    i_clear_start = 1'b0;
    i_zb_r_addr = '0;
    i_zb_w_we = 1'b0; i_zb_w_addr = '0; i_zb_w_data = '0;
    i_fb_we = 1'b0; i_fb_addr = '0; i_fb_pixel = '0;
    i_scan_start = 1'b0;
    sif.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    // Full clear, with a write to an already-cleared address that must drop
    i_clear_start = 1'b1;
    @(negedge clk);
    i_clear_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_bad = 0; prev_busy = 0;
    for (int k = 1; k <= N + 20; k++) begin
      if (o_clear_busy) busy_cnt++;
      if (o_clear_done) begin
        done_cnt++;
        if (o_clear_busy || !prev_busy) done_bad++;
      end
      prev_busy = o_clear_busy;
      i_fb_we = (k == 6);
      i_zb_w_we = (k == 6);
      i_fb_addr = 6'd2; i_fb_pixel = 12'hABC;
      i_zb_w_addr = 6'd2; i_zb_w_data = 8'h33;
      @(negedge clk);
    end
    i_fb_we = 1'b0; i_zb_w_we = 1'b0;
    chk("clear_busy_cycles", busy_cnt, N);
    chk("clear_done_count", done_cnt, 1);
    chk("clear_done_timing", done_bad, 0);
    for (int a = 0; a < N; a++) fbm[a] = 12'h000;

    for (int i = 0; i < 14; i++) begin
      i_zb_w_we = zt[i].we;
      i_zb_w_addr = zt[i].wa;
      i_zb_w_data = zt[i].wd;
      i_zb_r_addr = zt[i].ra;
      @(negedge clk);
`ifdef ZB_READ_BYPASS_EN
      ze = zt[i].exp_wf;
`else
      ze = zt[i].exp_rf;
`endif
      chk($sformatf("zb_vec%0d", i), o_zb_r_data, ze);
    end
    i_zb_w_we = 1'b0;

    i_fb_we = 1'b1; i_fb_addr = 6'd9; i_fb_pixel = 12'hF0A;
    fbm[9] = 12'hF0A;
    @(negedge clk);
    i_fb_addr = 6'd47; i_fb_pixel = 12'h777;
    fbm[47] = 12'h777;
    @(negedge clk);
    i_fb_addr = 6'd0; i_fb_pixel = 12'h001;
    fbm[0] = 12'h001;
    @(negedge clk);
    i_fb_addr = 6'd48; i_fb_pixel = 12'hFFF;
    @(negedge clk);
    i_fb_we = 1'b0;

    run_scan(1'b0, 1'b1);
    run_scan(1'b1, 1'b0);

    // Simultaneous starts, ignored scan start, then reset mid-clear
    i_clear_start = 1'b1; i_scan_start = 1'b1;
    @(negedge clk);
    i_clear_start = 1'b0; i_scan_start = 1'b0;
    chk("both_start_clear", o_clear_busy, 1);
    chk("both_start_scan", o_scan_busy, 0);
    for (int k = 2; k < 20; k++) begin
      i_scan_start = (k == 5);
      @(negedge clk);
    end
    i_scan_start = 1'b0;
    chk("scan_ignored", o_scan_busy, 0);
    chk("clear_mid", o_clear_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_clear");
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_clear_done || o_clear_busy || o_scan_busy) cnt++;
    end
    chk("no_done_after_abort", cnt, 0);

    // Reset mid-scan
    i_scan_start = 1'b1;
    @(negedge clk);
    i_scan_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("scan_mid_valid", sif.valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_scan");
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sif.valid || sif.last || o_scan_busy) cnt++;
    end
    chk("no_beat_after_abort", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
